// File: rtl/ifetch_prefetch.sv
// Instruction fetch front end: fetch PC, single-outstanding imem req/ack, prefetch FIFO.
// Optional halt-word detection is enabled by defining IFETCH_HALT_DETECT_EN.
module ifetch_prefetch #(
  parameter int unsigned         XLEN     = 32,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc
`ifdef IFETCH_HALT_DETECT_EN
  ,
  output logic            halted
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];

  logic            push, pop, halt_hit, halt_stop;
  logic [XLEN-1:0] redir_pc;
  logic            unused_redirect_lsbs;

  assign redir_pc             = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A redirect squashes both the returning word and any pop on the same edge.
  assign push = (state_q == StReq) && imem_ack && !redirect_valid;
  assign pop  = (count_q != '0) && instr_ready && !redirect_valid;

`ifdef IFETCH_HALT_DETECT_EN
  logic halted_q, halted_d;

  assign halt_hit  = (imem_rdata == 32'hFFFF_FFFF);
  assign halt_stop = halted_q;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid)         halted_d = 1'b0;
    else if (push && halt_hit)  halted_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  assign halted = halted_q;
`else
  assign halt_hit  = 1'b0;
  assign halt_stop = 1'b0;
`endif

  always_comb begin
    count_d  = count_q + CntW'(push) - CntW'(pop);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Next-state logic. addr_q holds the address of the outstanding request, which
  // differs from fetch_pc_q only while a squashed request drains in StDrop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          state_d    = StReq;
          fetch_pc_d = redir_pc;
          addr_d     = redir_pc;
        end else if ((count_q < CntW'(DEPTH)) && !halt_stop) begin
          state_d = StReq;
          addr_d  = fetch_pc_q;
        end
      end
      StReq: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_pc;
          if (imem_ack) begin
            addr_d = redir_pc;
          end else begin
            state_d = StDrop;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          addr_d     = fetch_pc_d;
          if (halt_hit || (count_d >= CntW'(DEPTH))) state_d = StIdle;
        end
      end
      StDrop: begin
        if (redirect_valid) fetch_pc_d = redir_pc;
        if (imem_ack) begin
          state_d = StReq;
          addr_d  = fetch_pc_d;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        data_mem_q[wr_ptr_q] <= imem_rdata;
      end
    end
  end

  always_comb begin
    imem_req    = (state_q != StIdle);
    imem_addr   = addr_q;
    instr_valid = (count_q != '0);
    instr       = data_mem_q[rd_ptr_q];
    instr_pc    = pc_mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch; memory word at address a is {16'hC0DE, a[15:0]}.
// Halt-detection steps run only when IFETCH_HALT_DETECT_EN is defined.
module tb_ifetch_prefetch;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req, imem_ack, instr_valid, instr_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
  logic        halt_inj;
  int          total = 0;
  int          bad = 0;
  int          ack_lat = 0;
  int          wait_cnt = 0;
`ifdef IFETCH_HALT_DETECT_EN
  logic        halted;
`endif

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // ack_lat==0 means ack tied high; otherwise ack on the ack_lat-th cycle of a request.
  assign imem_rdata = (halt_inj && imem_addr == 32'h8) ? 32'hFFFF_FFFF : mem_word(imem_addr);
  assign imem_ack   = (ack_lat == 0) ? 1'b1 : (imem_req && wait_cnt == ack_lat - 1);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  ifetch_prefetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef IFETCH_HALT_DETECT_EN
    ,
    .halted         (halted)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int lat);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    ack_lat        = lat;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    instr_ready = 1'b1; halt_inj = 1'b0;

    // Reset values, then zero-wait streaming.
    do_reset(0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    tick();
    chk("s1_req", imem_req, 1);
    chk("s1_addr0", imem_addr, 0);
    chk("s1_valid0", instr_valid, 0);
    for (int n = 2; n <= 6; n++) begin
      tick();
      chk("s1_valid", instr_valid, 1);
      chk("s1_pc", instr_pc, 32'(4 * (n - 2)));
      chk("s1_instr", instr, mem_word(32'(4 * (n - 2))));
      chk("s1_addr", imem_addr, 32'(4 * (n - 1)));
    end

    // Stalled core fills all four entries, then drains in order and refetches at 16.
    instr_ready = 1'b0;
    do_reset(0);
    tick(); tick(); tick(); tick();
    chk("s2_req_e4", imem_req, 1);
    chk("s2_addr_e4", imem_addr, 32'hC);
    tick();
    chk("s2_req_full", imem_req, 0);
    chk("s2_valid_full", instr_valid, 1);
    chk("s2_pc_head", instr_pc, 0);
    tick();
    chk("s2_req_hold", imem_req, 0);
    instr_ready = 1'b1;
    tick();
    chk("s2_drain0", instr_pc, 32'h4);
    chk("s2_req_idle", imem_req, 0);
    tick();
    chk("s2_drain1", instr_pc, 32'h8);
    chk("s2_refetch_req", imem_req, 1);
    chk("s2_refetch_addr", imem_addr, 32'h10);
    tick();
    chk("s2_drain2", instr_pc, 32'hC);
    tick();
    chk("s2_new_pc", instr_pc, 32'h10);
    chk("s2_new_instr", instr, mem_word(32'h10));

    // Three-cycle memory latency.
    do_reset(3);
    tick();
    chk("s3_req", imem_req, 1);
    chk("s3_addr_c0", imem_addr, 0);
    tick();
    chk("s3_addr_c1", imem_addr, 0);
    chk("s3_valid_c1", instr_valid, 0);
    tick();
    chk("s3_addr_c2", imem_addr, 0);
    chk("s3_valid_c2", instr_valid, 0);
    tick();
    chk("s3_valid_w0", instr_valid, 1);
    chk("s3_pc_w0", instr_pc, 0);
    chk("s3_addr_w1", imem_addr, 32'h4);
    tick();
    chk("s3_valid_gap0", instr_valid, 0);
    tick();
    chk("s3_valid_gap1", instr_valid, 0);
    chk("s3_addr_stable", imem_addr, 32'h4);
    tick();
    chk("s3_valid_w1", instr_valid, 1);
    chk("s3_pc_w1", instr_pc, 32'h4);
    chk("s3_addr_w2", imem_addr, 32'h8);

    // Redirect to 0x103 while the request to 0x8 is still outstanding.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    chk("s4_drop_req", imem_req, 1);
    chk("s4_drop_addr", imem_addr, 32'h8);
    chk("s4_drop_valid", instr_valid, 0);
    tick();
    chk("s4_new_addr", imem_addr, 32'h100);
    chk("s4_no_old_word", instr_valid, 0);
    tick();
    chk("s4_wait0", instr_valid, 0);
    tick();
    chk("s4_wait1", instr_valid, 0);
    tick();
    chk("s4_first_valid", instr_valid, 1);
    chk("s4_first_pc", instr_pc, 32'h100);
    chk("s4_first_instr", instr, mem_word(32'h100));

    // Redirect on the same edge as an ack and a pop.
    do_reset(0);
    tick(); tick();
    chk("s5_pre_pc", instr_pc, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("s5_flush_valid", instr_valid, 0);
    chk("s5_req", imem_req, 1);
    chk("s5_addr", imem_addr, 32'h40);
    tick();
    chk("s5_new_valid", instr_valid, 1);
    chk("s5_new_pc", instr_pc, 32'h40);
    chk("s5_new_instr", instr, mem_word(32'h40));

    // Reset in the middle of an outstanding request.
    do_reset(3);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("s6_req", imem_req, 0);
    chk("s6_addr", imem_addr, 0);
    chk("s6_valid", instr_valid, 0);
    rst = 1'b0;
    tick();
    chk("s6_restart_req", imem_req, 1);
    chk("s6_restart_addr", imem_addr, 0);

`ifdef IFETCH_HALT_DETECT_EN
    halt_inj = 1'b1;
    do_reset(0);
    chk("h_rst_halted", halted, 0);
    tick(); tick(); tick();
    tick();
    chk("h_valid", instr_valid, 1);
    chk("h_pc", instr_pc, 32'h8);
    chk("h_instr", instr, 32'hFFFF_FFFF);
    chk("h_halted", halted, 1);
    chk("h_req_off", imem_req, 0);
    tick();
    chk("h_req_stay_off", imem_req, 0);
    chk("h_drained", instr_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    redirect_valid = 1'b0;
    chk("h_cleared", halted, 0);
    chk("h_resume_req", imem_req, 1);
    chk("h_resume_addr", imem_addr, 0);
    tick();
    chk("h_resume_pc", instr_pc, 0);
    halt_inj = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Instruction fetch front end for the RISC-V core. Sits directly upstream of the single-cycle decode/execute path. Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core over valid/ready. A redirect from the core (branch/jump) flushes the buffer and restarts fetch at the new PC.

## Interface
- XLEN, 32, data/address width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- RESET_PC, 32'h0, first fetch address after reset
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
- imem_req  out  1  request to instruction memory
- imem_addr  out  XLEN  word-aligned fetch address
- imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word
- instr_valid  out  1  FIFO head is valid
- instr_ready  in  1  core consumes head this cycle
- instr  out  32  head instruction word
- instr_pc  out  XLEN  PC of head instruction

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DROP: squashed request outstanding; its data will be discarded.
- IDLE→REQ when count<DEPTH and not halted. Drive imem_req=1 and imem_addr=fetch_pc.
- In REQ, imem_req and imem_addr are held stable until imem_ack.
- On ack in REQ:
  - Push {fetch_pc, imem_rdata} into the FIFO.
  - fetch_pc += 4, wrapping modulo 2^XLEN.
  - Stay in REQ with the new address if count-after-update < DEPTH; else go to IDLE.
- At most one request outstanding. Guarantee: a push never overflows.
- Pop when instr_valid && instr_ready. Simultaneous push and pop leaves count unchanged.
- Redirect on an edge with redirect_valid=1:
  - count→0; any pop that edge is ignored.
  - fetch_pc←{redirect_pc[XLEN-1:2],2'b00}.
  - If REQ without ack that edge → DROP; the outstanding req stays asserted with the old address until ack.
  - If ack arrives the same edge as the redirect, that word is discarded. Next state is REQ at the new PC.
  - From IDLE → REQ at the new PC.
- DROP: on ack, discard data → REQ at fetch_pc. A second redirect while in DROP only updates fetch_pc.
- rst mid-transaction: everything returns to reset values immediately. A memory ack arriving later with imem_req=0 is ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0.
  - FSM=IDLE, count=0, fetch_pc=RESET_PC.
- imem_req rises on the first rising edge with rst=0.
- Fetch latency: instr_valid=1 one cycle after the edge that samples imem_ack.
- Throughput: one word per cycle with a zero-wait memory (ack tied high) and a continuously ready core.
- Redirect: instr_valid=0 the cycle after the redirect edge. First new-path word becomes valid ≥2 cycles after the redirect edge.
- All outputs are registered or driven from FIFO registers. There is no combinational path from inputs to outputs.

## Configuration
- IFETCH_HALT_DETECT_EN defined:
  - Adds output port halted (1 bit, reset 0).
  - On acceptance (not drop) of imem_rdata==32'hFFFFFFFF, the word is pushed, halted←1, and the FSM goes to IDLE with no further requests.
  - halted clears only on redirect_valid or rst.
- Undefined: no halted port; 32'hFFFFFFFF is an ordinary instruction word.

## Test plan
- Reset release, RESET_PC=0, ack always 1, ready always 1 → imem_addr 0,4,8,… on consecutive cycles; instr_pc matches; instr equals memory word; one instruction per cycle.
- instr_ready=0 held, zero-wait memory → exactly DEPTH=4 words buffered (PCs 0,4,8,12); imem_req drops; re-raising ready drains 0,4,8,12 in order, then fetch resumes at 16.
- Memory with 3-cycle ack latency → imem_addr stable for 3 cycles per request; instr_valid pulses once per 3 cycles.
- redirect_pc=0x103 while a request to 0x8 is outstanding → 0x8 held until ack, its data discarded; next request is at 0x100; first valid instr_pc=0x100; nothing from the old path delivered.
- Redirect on the same edge as an ack and a pop → FIFO empty next cycle; the acked word is never delivered; fetch restarts at the redirect PC.
- With IFETCH_HALT_DETECT_EN, word 0xFFFFFFFF at PC 0x8 → delivered, halted=1, no request after PC 0x8; a redirect to 0x0 clears halted and fetch resumes.
